// File: rtl/cv_tmds_enc.sv
// cv_tmds_enc: DVI 1.0 TMDS 8b/10b encoder for one colour channel.
// Stage 1 minimises transitions (q_m); stage 2 balances DC and emits the symbol.
module cv_tmds_enc (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       de_i,
    input  logic [7:0] din_i,
    input  logic       c0_i,
    input  logic       c1_i,
    output logic [9:0] dout_o
);
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    logic [3:0]        n1;
    logic              use_xnor;
    logic              b;
    logic [8:0]        qm_d, qm_q;
    logic              de_q, c0_q, c1_q;
    logic [3:0]        nq1;
    logic signed [4:0] diff;
    logic              br_a, br_b;
    logic signed [4:0] cnt_d, cnt_q;
    logic [9:0]        ctrl, dout_d, dout_q;

    always_comb begin
        n1 = '0;
        for (int i = 0; i < 8; i++) n1 = n1 + 4'(din_i[i]);
        use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !din_i[0]);
        b = din_i[0];
        qm_d = {~use_xnor, 8'h00};
        qm_d[0] = b;
        for (int i = 1; i < 8; i++) begin
            b = use_xnor ? ~(b ^ din_i[i]) : (b ^ din_i[i]);
            qm_d[i] = b;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            qm_q <= '0;
            de_q <= 1'b0;
            c0_q <= 1'b0;
            c1_q <= 1'b0;
        end else begin
            qm_q <= qm_d;
            de_q <= de_i;
            c0_q <= c0_i;
            c1_q <= c1_i;
        end
    end

    // diff = nq1 - nq0 = 2*nq1 - 8; mod-32 wrap is exact because the result lies in -8..8
    always_comb begin
        nq1 = '0;
        for (int i = 0; i < 8; i++) nq1 = nq1 + 4'(qm_q[i]);
        diff = $signed({nq1, 1'b0}) - 5'sd8;
        br_a = (cnt_q == 5'sd0) || (diff == 5'sd0);
        br_b = !br_a && (cnt_q[4] == diff[4]);
        ctrl = c1_q ? (c0_q ? CTRL_11 : CTRL_10) : (c0_q ? CTRL_01 : CTRL_00);
        dout_d = !de_q ? ctrl :
                 br_a  ? {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]} :
                 br_b  ? {1'b1, qm_q[8], ~qm_q[7:0]} :
                         {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d = !de_q ? 5'sd0 :
                br_a  ? cnt_q + (qm_q[8] ? diff : -diff) :
                br_b  ? cnt_q + $signed({3'b000, qm_q[8], 1'b0}) - diff :
                        cnt_q + diff - $signed({3'b000, ~qm_q[8], 1'b0});
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dout_q <= CTRL_00;
            cnt_q  <= 5'sd0;
        end else begin
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout_o = dout_q;
endmodule
